speed_pi_regulator_module: RTL and testbench
============================================

Name: speed_pi_regulator_module

Overview:
- Speed-loop PI controller placed directly downstream of speed_detection_module.
- Consumes the Q15 standardized speed feedback (full scale = rated speed) and a Q15 speed reference.
- Produces a saturated Q15 q-axis current reference for the current loop.
- One computation per speed sample, using a small FSM and a shared multiplier.

Parameters:
- DATA_WIDTH, 16, width of speed/current words (signed Q15).
- KP_SHIFT, 12, right shift applied to kp*err (kp=4096 gives gain 1.0).
- KI_SHIFT, 15, right shift applied to ki*err (ki=32768 gives 1.0 per sample).
- ACC_WIDTH, 32, integrator accumulator width.

Ports:
- sys_clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable_in  in  1  regulator enable; low clears integrator and output
- speed_valid_in  in  1  one-cycle strobe: new feedback sample present
- speed_ref_in  in  16  signed Q15 speed reference
- speed_fbk_in  in  16  signed Q15 speed feedback (standardization_speed_out)
- kp_in  in  16  unsigned proportional gain
- ki_in  in  16  unsigned integral gain
- iq_limit_in  in  15  unsigned symmetric output/integrator limit
- iq_ref_out  out  16  signed Q15 current reference
- iq_ref_valid_out  out  1  one-cycle strobe: iq_ref_out updated
- saturation_out  out  1  last output was clamped
- busy_out  out  1  computation in progress

Behaviour:
- Reset: all outputs 0, integrator 0, FSM in IDLE. A reset asserted mid-computation aborts it with no valid strobe.
- FSM: IDLE -> ERR -> PMUL -> IMUL -> SUM -> OUT -> IDLE.
  - IDLE: leaves on speed_valid_in=1 with enable_in=1, latching ref, fbk, kp, ki and limit.
  - ERR: err = ref - fbk computed in 17 bits, saturated to [-32768, 32767].
  - PMUL: p = (kp*err) >>> KP_SHIFT (arithmetic shift).
  - IMUL: di = (ki*err) >>> KI_SHIFT.
  - SUM: acc_new = acc + di. The integrator is clamped to [-limit, +limit], which provides anti-windup. sum = p + clamped acc, in ACC_WIDTH bits.
  - OUT: iq_ref_out = sum clamped to [-limit, +limit]; saturation_out = 1 if clamped, else 0; iq_ref_valid_out = 1 for exactly one cycle.
- Latency: strobe at edge N gives iq_ref_valid_out high in the cycle after edge N+5.
- busy_out = 1 in every state other than IDLE.
- speed_valid_in while busy: sample dropped, no queueing, state unaffected.
- enable_in low:
  - In IDLE: integrator cleared, iq_ref_out forced to 0, saturation_out 0, no strobes.
  - Mid-computation: the current computation completes normally; clearing takes effect on return to IDLE.
- limit = 0: output and integrator are held at 0; saturation_out = 1 whenever the unclamped sum is nonzero.
- Held values: iq_ref_out holds between updates; gains and limit are sampled only at IDLE exit.
- No arithmetic wrap-around anywhere; every narrowing step saturates.

Optional Feature:
- Macro: SPEED_PI_DEADBAND_EN.
- When defined:
  - Added parameter DEADBAND, default 8.
  - In ERR, |err| <= DEADBAND forces err = 0, so there is no P contribution and no integration. This suppresses encoder-quantization chatter at near-zero speed.
- When undefined: the deadband logic and parameter are absent and err is used as-is.

Decomposition:
- Shared package pmsm_ctrl_pkg contains:
  - state enum speed_pi_state_t;
  - Q15 constants Q15_MAX = 32767 and Q15_MIN = -32768;
  - function sat_q15 for signed saturation of a wide value to 16 bits;
  - function clamp_sym for symmetric limit clamping.
- One natural sub-module: pi_sat_mac_unit, holding the shared 16x16 signed-by-unsigned multiply, arithmetic shift and symmetric clamp. It is instantiated once and time-shared between PMUL and IMUL.

Test Plan:
- Reset and idle: assert reset with a strobe in flight -> iq_ref_out=0, no iq_ref_valid_out, busy_out=0 on the cycle after release.
- Pure P: kp=4096, ki=0, limit=32767, ref=1000, fbk=0, strobe -> iq_ref_out=1000 in the cycle after edge N+5, saturation_out=0.
- Pure I ramp: kp=0, ki=32768, ref=100, fbk=0, four strobes 20 cycles apart -> outputs 100, 200, 300, 400. Then enable_in=0 -> output 0; re-enable with one strobe -> 100.
- Saturation/anti-windup: kp=4096, ki=32768, limit=2000, ref=30000, fbk=-30000 -> err=32767, iq_ref_out=2000, saturation_out=1. Then ref=fbk=0 -> output 2000 (integrator held at 2000, not wound up); then ref=0, fbk=500, kp=0 -> output 1500.
- Busy drop: two strobes 2 cycles apart -> exactly one iq_ref_valid_out, computed from the first sample's values.
- Deadband (SPEED_PI_DEADBAND_EN, DEADBAND=8): kp=4096, ref=5, fbk=0 -> output 0; ref=9 -> output 9.

Source files
------------

// File: rtl/pmsm_ctrl_pkg.sv
// Shared PMSM control types and Q15 helpers: speed-PI FSM states, Q15 bounds,
// and the saturating / symmetric-clamp narrowing functions.
package pmsm_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_PMUL,
        S_IMUL,
        S_SUM,
        S_OUT
    } speed_pi_state_t;

    localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q15_MIN = 16'sh8000;

    function automatic logic signed [15:0] sat_q15(input logic signed [63:0] v);
        if (v > 64'sd32767)
            return Q15_MAX;
        else if (v < -64'sd32768)
            return Q15_MIN;
        else
            return v[15:0];
    endfunction

    // Clamp to [-lim, +lim]; lim <= 32767 so the result always fits in Q15.
    function automatic logic signed [15:0] clamp_sym(input logic signed [63:0] v,
                                                     input logic [14:0] lim);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = {49'd0, lim};
        lo = -hi;
        r  = v;
        if (v > hi)
            r = hi;
        else if (v < lo)
            r = lo;
        return r[15:0];
    endfunction

endpackage

// File: rtl/pi_sat_mac_unit.sv
// Shared signed-by-unsigned multiply with selectable arithmetic shift, plus a
// symmetric clamp; time-shared across the PI regulator's states.
module pi_sat_mac_unit
    import pmsm_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int KP_SHIFT   = 12,
    parameter int KI_SHIFT   = 15
) (
    input  logic signed [DATA_WIDTH-1:0] err,
    input  logic        [DATA_WIDTH-1:0] gain,
    input  logic                         use_ki,
    input  logic signed [ACC_WIDTH:0]    clamp_in,
    input  logic        [DATA_WIDTH-2:0] limit,
    output logic signed [ACC_WIDTH-1:0]  prod_out,
    output logic signed [DATA_WIDTH-1:0] clamp_out,
    output logic                         clamped
);

    localparam int PW = 2 * DATA_WIDTH + 1;
    localparam logic signed [63:0] ACC_MAX = (64'sd1 <<< (ACC_WIDTH - 1)) - 64'sd1;
    localparam logic signed [63:0] ACC_MIN = -(64'sd1 <<< (ACC_WIDTH - 1));

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic signed [63:0]   wide;
    logic signed [63:0]   clamp_wide;

    always_comb begin
        // Gain is unsigned: zero-extend it into a signed operand before multiplying.
        prod    = PW'($signed({1'b0, gain})) * PW'(err);
        shifted = use_ki ? (prod >>> KI_SHIFT) : (prod >>> KP_SHIFT);
        wide    = 64'(shifted);
        if (wide > ACC_MAX)
            prod_out = ACC_MAX[ACC_WIDTH-1:0];
        else if (wide < ACC_MIN)
            prod_out = ACC_MIN[ACC_WIDTH-1:0];
        else
            prod_out = wide[ACC_WIDTH-1:0];

        clamp_wide = 64'(clamp_in);
        clamp_out  = clamp_sym(clamp_wide, limit);
        clamped    = (clamp_wide != 64'(clamp_out));
    end

endmodule

// File: rtl/speed_pi_regulator_module.sv
// Speed-loop PI regulator: Q15 speed error -> clamped Q15 iq reference, one
// multi-cycle computation per speed sample. SPEED_PI_DEADBAND_EN adds an error deadband.
module speed_pi_regulator_module
    import pmsm_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int KP_SHIFT   = 12,
    parameter int KI_SHIFT   = 15,
    parameter int ACC_WIDTH  = 32
`ifdef SPEED_PI_DEADBAND_EN
    ,
    parameter int DEADBAND   = 8
`endif
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  enable_in,
    input  logic                  speed_valid_in,
    input  logic [DATA_WIDTH-1:0] speed_ref_in,
    input  logic [DATA_WIDTH-1:0] speed_fbk_in,
    input  logic [DATA_WIDTH-1:0] kp_in,
    input  logic [DATA_WIDTH-1:0] ki_in,
    input  logic [DATA_WIDTH-2:0] iq_limit_in,
    output logic [DATA_WIDTH-1:0] iq_ref_out,
    output logic                  iq_ref_valid_out,
    output logic                  saturation_out,
    output logic                  busy_out
);

    speed_pi_state_t state_reg, state_next;

    logic signed [DATA_WIDTH-1:0] ref_reg, fbk_reg, err_reg, iq_reg;
    logic        [DATA_WIDTH-1:0] kp_reg, ki_reg;
    logic        [DATA_WIDTH-2:0] lim_reg;
    logic signed [ACC_WIDTH-1:0]  p_reg, di_reg, acc_reg, sum_reg;
    logic                         valid_reg, sat_reg;

    logic signed [DATA_WIDTH:0]   diff;
    logic signed [DATA_WIDTH-1:0] err_val;
    logic signed [ACC_WIDTH:0]    acc_sum, clamp_in, sum_wide;
    logic signed [ACC_WIDTH-1:0]  sum_sat, prod_val;
    logic signed [DATA_WIDTH-1:0] clamp_val;
    logic                         clamped;

    pi_sat_mac_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .KP_SHIFT  (KP_SHIFT),
        .KI_SHIFT  (KI_SHIFT)
    ) u_mac (
        .err      (err_reg),
        .gain     ((state_reg == S_IMUL) ? ki_reg : kp_reg),
        .use_ki   (state_reg == S_IMUL),
        .clamp_in (clamp_in),
        .limit    (lim_reg),
        .prod_out (prod_val),
        .clamp_out(clamp_val),
        .clamped  (clamped)
    );

    always_comb begin
        diff    = {ref_reg[DATA_WIDTH-1], ref_reg} - {fbk_reg[DATA_WIDTH-1], fbk_reg};
        err_val = sat_q15(64'(diff));
`ifdef SPEED_PI_DEADBAND_EN
        if (err_val >= -DEADBAND && err_val <= DEADBAND)
            err_val = '0;
`endif
        acc_sum  = {acc_reg[ACC_WIDTH-1], acc_reg} + {di_reg[ACC_WIDTH-1], di_reg};
        // The clamp serves the integrator in SUM and the output in OUT.
        clamp_in = (state_reg == S_OUT) ? {sum_reg[ACC_WIDTH-1], sum_reg} : acc_sum;
        sum_wide = {p_reg[ACC_WIDTH-1], p_reg} + (ACC_WIDTH + 1)'(clamp_val);
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
            sum_sat = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            sum_sat = sum_wide[ACC_WIDTH-1:0];
    end

    always_ff @(posedge sys_clk) begin
        if (reset)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (speed_valid_in && enable_in) state_next = S_ERR;
            S_ERR:   state_next = S_PMUL;
            S_PMUL:  state_next = S_IMUL;
            S_IMUL:  state_next = S_SUM;
            S_SUM:   state_next = S_OUT;
            S_OUT:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            ref_reg   <= '0;
            fbk_reg   <= '0;
            kp_reg    <= '0;
            ki_reg    <= '0;
            lim_reg   <= '0;
            err_reg   <= '0;
            p_reg     <= '0;
            di_reg    <= '0;
            acc_reg   <= '0;
            sum_reg   <= '0;
            iq_reg    <= '0;
            sat_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (!enable_in) begin
                        acc_reg <= '0;
                        iq_reg  <= '0;
                        sat_reg <= 1'b0;
                    end else if (speed_valid_in) begin
                        ref_reg <= speed_ref_in;
                        fbk_reg <= speed_fbk_in;
                        kp_reg  <= kp_in;
                        ki_reg  <= ki_in;
                        lim_reg <= iq_limit_in;
                    end
                end
                S_ERR:  err_reg <= err_val;
                S_PMUL: p_reg   <= prod_val;
                S_IMUL: di_reg  <= prod_val;
                S_SUM: begin
                    acc_reg <= ACC_WIDTH'(clamp_val);
                    sum_reg <= sum_sat;
                end
                S_OUT: begin
                    iq_reg    <= clamp_val;
                    sat_reg   <= clamped;
                    valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign iq_ref_out       = iq_reg;
    assign iq_ref_valid_out = valid_reg;
    assign saturation_out   = sat_reg;
    assign busy_out         = (state_reg != S_IDLE);

endmodule

// File: tb/tb_speed_pi_regulator_module.sv
// Scoreboard bench for speed_pi_regulator_module: directed strobes push expected
// results; a negedge monitor pops and compares on every iq_ref_valid_out.
module tb_speed_pi_regulator_module;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_in = 1'b0;
    logic        speed_valid_in = 1'b0;
    logic [15:0] speed_ref_in = '0;
    logic [15:0] speed_fbk_in = '0;
    logic [15:0] kp_in = '0;
    logic [15:0] ki_in = '0;
    logic [14:0] iq_limit_in = '0;
    logic [15:0] iq_ref_out;
    logic        iq_ref_valid_out;
    logic        saturation_out;
    logic        busy_out;

    speed_pi_regulator_module dut (
        .sys_clk         (sys_clk),
        .reset           (reset),
        .enable_in       (enable_in),
        .speed_valid_in  (speed_valid_in),
        .speed_ref_in    (speed_ref_in),
        .speed_fbk_in    (speed_fbk_in),
        .kp_in           (kp_in),
        .ki_in           (ki_in),
        .iq_limit_in     (iq_limit_in),
        .iq_ref_out      (iq_ref_out),
        .iq_ref_valid_out(iq_ref_valid_out),
        .saturation_out  (saturation_out),
        .busy_out        (busy_out)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int    iq;
        int    sat;
        int    cyc;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pushed = 0;
    int   seen = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    always @(negedge sys_clk) begin
        if (iq_ref_valid_out) begin
            exp_t e;
            seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_iq"}, int'($signed(iq_ref_out)), e.iq);
                check({e.name, "_sat"}, int'(saturation_out), e.sat);
                check({e.name, "_latency"}, cyc, e.cyc);
                $display("txn %s: iq=%0d sat=%0b cycle=%0d", e.name,
                         $signed(iq_ref_out), saturation_out, cyc);
            end
        end
    end

    // One-cycle strobe; when push is set the expected result is queued for edge N+5.
    task automatic strobe(input int r, input int f, input int kp, input int ki, input int lim,
                          input bit push, input int eiq, input int esat, input string nm);
        exp_t e;
        @(posedge sys_clk);
        #1;
        speed_ref_in   = 16'(r);
        speed_fbk_in   = 16'(f);
        kp_in          = 16'(kp);
        ki_in          = 16'(ki);
        iq_limit_in    = 15'(lim);
        speed_valid_in = 1'b1;
        @(posedge sys_clk);
        #1;
        speed_valid_in = 1'b0;
        if (push) begin
            e.iq   = eiq;
            e.sat  = esat;
            e.cyc  = cyc + 5;
            e.name = nm;
            exp_q.push_back(e);
            pushed++;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sys_clk);
    endtask

    task automatic clear_integrator();
        @(posedge sys_clk);
        #1 enable_in = 1'b0;
        wait_cycles(2);
        #1 enable_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=%0d required=%0d", cyc, 0);
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cycles(3);
        #1 reset = 1'b0;
        @(negedge sys_clk);
        check("reset_iq", int'(iq_ref_out), 0);
        check("reset_busy", int'(busy_out), 0);
        enable_in = 1'b1;

        strobe(1000, 0, 4096, 0, 32767, 1, 1000, 0, "pure_p");
        wait_cycles(15);

        // Reset lands mid-computation: no strobe, everything back to zero.
        strobe(2000, 0, 4096, 0, 32767, 0, 0, 0, "");
        wait_cycles(1);
        #1 reset = 1'b1;
        wait_cycles(2);
        #1 reset = 1'b0;
        @(negedge sys_clk);
        check("abort_iq", int'(iq_ref_out), 0);
        check("abort_valid", int'(iq_ref_valid_out), 0);
        check("abort_busy", int'(busy_out), 0);
        wait_cycles(10);

        for (int k = 1; k <= 4; k++) begin
            strobe(100, 0, 0, 32768, 32767, 1, 100 * k, 0, $sformatf("ramp%0d", k));
            wait_cycles(18);
        end
        #1 enable_in = 1'b0;
        wait_cycles(3);
        @(negedge sys_clk);
        check("disable_iq", int'(iq_ref_out), 0);
        #1 enable_in = 1'b1;
        strobe(100, 0, 0, 32768, 32767, 1, 100, 0, "reenable");
        wait_cycles(15);

        clear_integrator();
        strobe(30000, -30000, 4096, 32768, 2000, 1, 2000, 1, "windup");
        wait_cycles(15);
        strobe(0, 0, 4096, 32768, 2000, 1, 2000, 0, "hold");
        wait_cycles(15);
        strobe(0, 500, 0, 32768, 2000, 1, 1500, 0, "unwind");
        wait_cycles(15);

        clear_integrator();
        strobe(-30000, 30000, 4096, 0, 1000, 1, -1000, 1, "neg_clamp");
        wait_cycles(15);
        strobe(0, 7, 1000, 0, 32767, 1, -2, 0, "neg_shift");
        wait_cycles(15);

        clear_integrator();
        strobe(100, 0, 4096, 32768, 0, 1, 0, 1, "zero_lim");
        wait_cycles(15);
        strobe(0, 0, 4096, 32768, 0, 1, 0, 0, "zero_lim_idle");
        wait_cycles(15);

        clear_integrator();
        strobe(300, 0, 4096, 0, 32767, 1, 300, 0, "busy_first");
        @(posedge sys_clk);
        #1;
        speed_ref_in   = 16'd7000;
        speed_valid_in = 1'b1;
        @(posedge sys_clk);
        #1 speed_valid_in = 1'b0;
        wait_cycles(15);

`ifdef SPEED_PI_DEADBAND_EN
        strobe(5, 0, 4096, 0, 32767, 1, 0, 0, "deadband_in");
`else
        strobe(5, 0, 4096, 0, 32767, 1, 5, 0, "deadband_in");
`endif
        wait_cycles(15);
        strobe(9, 0, 4096, 0, 32767, 1, 9, 0, "deadband_out");
        wait_cycles(15);

        check("pending_expectations", exp_q.size(), 0);
        check("valid_count", seen, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
